// File: rtl/mips16_boot_pkg.sv
// Shared types and constants for the mips_16bit instruction-memory boot loader.
// Holds the loader state encoding, bus widths and the default idle timeout.
package mips16_boot_pkg;

    localparam int BYTE_W          = 8;
    localparam int INSTR_W         = 16;
    localparam int DEFAULT_TIMEOUT = 1000;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CSUM,
        DONE,
        ERROR
    } boot_state_t;

    // States in which the loader is willing to take a byte from the stream.
    function automatic logic rx_open(input boot_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
               (s == DATA_LO) || (s == CSUM);
    endfunction

    // States in which the idle watchdog runs; a load has not started in LEN_HI.
    function automatic logic timed_state(input boot_state_t s);
        return (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave is the loader's view; master is the feeder/memory side.
interface imem_boot_loader_if
    import mips16_boot_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic                rx_valid;
    logic [BYTE_W-1:0]   rx_data;
    logic                rx_ready;
    logic                imem_we;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/boot_idle_timer.sv
// Idle watchdog: counts enabled cycles since the last clear, flags TIMEOUT-1.
// One-cycle clear latency; the count holds at the terminal value until cleared.
module boot_idle_timer
    import mips16_boot_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    assign tc = (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Assembles a length/words/XOR-checksum byte stream into imem writes; one write a cycle after each low byte.
// Takes a byte every cycle while loading; holds rx_ready low and the CPU in reset on error.
module imem_boot_loader
    import mips16_boot_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_boot_loader_if.slave    bus,
    output logic                 cpu_reset,
    output logic                 load_done,
    output logic                 load_error,
    output logic [ADDR_W:0]      words_loaded
);
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    boot_state_t          state;
    boot_state_t          state_next;

    logic                 rx_ready_q;
    logic                 imem_we_q;
    logic [ADDR_W-1:0]    imem_addr_q;
    logic [INSTR_W-1:0]   imem_wdata_q;

    logic [BYTE_W-1:0]    len_hi;
    logic [15:0]          len;
    logic [BYTE_W-1:0]    word_hi;
    logic [BYTE_W-1:0]    csum;

    logic                 accept;
    logic                 timed;
    logic                 idle_tc;
    logic                 last_word;
    logic [15:0]          len_full;
    logic [ADDR_W:0]      wl_inc;

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;

    assign accept    = bus.rx_valid && rx_ready_q;
    assign timed     = timed_state(state);
    assign len_full  = {len_hi, bus.rx_data};
    assign wl_inc    = words_loaded + (ADDR_W + 1)'(1);
    assign last_word = (17'(wl_inc) == {1'b0, len});

    boot_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (accept || !timed),
        .en    (timed),
        .tc    (idle_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LEN_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LEN_HI: begin
                if (accept) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len_full} > DEPTH) begin
                        state_next = ERROR;
                    end else if (len_full == '0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) state_next = DATA_LO;
            end
            DATA_LO: begin
                if (accept) state_next = last_word ? CSUM : DATA_HI;
            end
            CSUM: begin
                if (accept) state_next = (bus.rx_data == csum) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                state_next = state;
            end
            default: begin
                state_next = ERROR;
            end
        endcase
        // A byte landing on the terminal idle cycle still counts as progress.
        if (timed && idle_tc && !accept) begin
            state_next = ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            len_hi       <= '0;
            len          <= '0;
            word_hi      <= '0;
            csum         <= '0;
        end else begin
            rx_ready_q <= rx_open(state_next);
            imem_we_q  <= 1'b0;
            cpu_reset  <= (state != DONE);
            load_done  <= (state == DONE);
            load_error <= (state == ERROR);
            if (accept) begin
                csum <= csum ^ bus.rx_data;
                case (state)
                    LEN_HI:  len_hi  <= bus.rx_data;
                    LEN_LO:  len     <= len_full;
                    DATA_HI: word_hi <= bus.rx_data;
                    DATA_LO: begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= words_loaded[ADDR_W-1:0];
                        imem_wdata_q <= {word_hi, bus.rx_data};
                        words_loaded <= wl_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Upstream feeder for mips_16bit. It receives a program image as a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words. Each word is written into the instruction memory write port. mips_16bit is held in reset (cpu_reset) until the full image has arrived and its checksum matches; the CPU then starts fetching from PC 0.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity DEPTH = 2**ADDR_W words
TIMEOUT, 1000, maximum idle clk cycles between accepted bytes once a load has started

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
rx_valid  in  1  byte available on rx_data
rx_data  in  8  incoming byte
rx_ready  out  1  loader can accept a byte
imem_we  out  1  instruction memory write strobe, one cycle per word
imem_addr  out  ADDR_W  word address of the write
imem_wdata  out  16  instruction word being written
cpu_reset  out  1  drives the reset input of mips_16bit
load_done  out  1  image loaded and checksum verified
load_error  out  1  load failed: length overflow, checksum mismatch or timeout
words_loaded  out  ADDR_W+1  count of words written in the current load

Behaviour:
- Reset is synchronous and active-high; clk is the single clock.
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, words_loaded=0. State is LEN_HI.
- Stream format, in order:
  - length high byte, then length low byte (length counts 16-bit words);
  - length words, each sent high byte then low byte;
  - one checksum byte, equal to the XOR of every preceding byte, including both length bytes.
- A byte is accepted when rx_valid && rx_ready on a rising edge.
- rx_ready=1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM. It is 0 in DONE and ERROR, and 0 in the first cycle after reset.
- Each accepted byte is XORed into the running checksum register, which is cleared on reset.
- State transitions:
  - LEN_HI -> LEN_LO on accept. No timeout applies in LEN_HI.
  - LEN_LO -> on accept, with len = {hi,lo}:
    - len > DEPTH -> ERROR;
    - len == 0 -> CSUM;
    - otherwise -> DATA_HI.
  - DATA_HI -> DATA_LO on accept; the byte is latched as the upper 8 bits of the word.
  - DATA_LO -> on accept:
    - the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = words_loaded (old value) and imem_wdata = {hi,lo};
    - words_loaded increments in that same cycle;
    - go to CSUM if this was word len, else DATA_HI.
  - CSUM -> on accept:
    - byte equals the running XOR -> DONE;
    - otherwise -> ERROR.
  - DONE is terminal until reset. From the cycle after entry: load_done=1 and cpu_reset=0. In the same entry cycle imem_we is 0, because the last write has already completed.
  - ERROR is terminal until reset: load_error=1, cpu_reset stays 1.
- Timeout:
  - An idle counter runs in LEN_LO, DATA_HI, DATA_LO and CSUM, and clears on every accepted byte.
  - When the counter reaches TIMEOUT-1 with no accept in that cycle -> ERROR.
  - If an accept and the terminal count occur in the same cycle, the accept wins.
- Back-to-back bytes (rx_valid held high) are accepted every cycle, with no bubbles.
- Reset asserted mid-load returns everything to its reset values on the next edge. Memory contents already written are not cleared.
- load_done and load_error are never both 1.
- cpu_reset never returns to 1 except through reset.

Decomposition:
- Package mips16_boot_pkg holds:
  - the state enum: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERROR;
  - BYTE_W=8 and INSTR_W=16;
  - the default TIMEOUT constant.
- One natural sub-module: boot_idle_timer, a loadable clear/enable counter with a terminal-count output, parameterised by TIMEOUT.
- The FSM, word assembly, checksum and write port stay in the top module.

Test Plan:
- Nominal load: bytes 00 02 12 34 AB CD 42, rx_valid held high -> imem writes addr0=0x1234 and addr1=0xABCD on consecutive write pulses; words_loaded=2; load_done=1; cpu_reset falls to 0 one cycle after the 0x42 byte is accepted.
- Bad checksum: same stream with final byte 0x43 -> no further writes after addr1; load_error=1; cpu_reset stays 1; rx_ready=0.
- Zero length: 00 00 00 -> no imem_we pulses; load_done=1; words_loaded=0.
- Overflow with ADDR_W=8: 01 01 -> ERROR immediately after the second byte; no writes.
- Timeout with TIMEOUT=16: 00 01 12, then rx_valid low for 16 cycles -> load_error=1; a 0x34 sent afterwards is not accepted.
- Reset mid-load: assert reset after 00 02 12 34 -> all outputs at reset values; a full nominal reload then succeeds, with rx_valid toggled randomly to exercise stalls.
